// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    // Transfer-size codes; the arbiter passes them through untouched.
    localparam logic [2:0] BHW_BYTE = 3'd0;
    localparam logic [2:0] BHW_HALF = 3'd1;
    localparam logic [2:0] BHW_WORD = 3'd2;

    // Master indices: M0 = CPU, M1 = DMA / SD-card engine.
    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    // Round-robin choice: with both pending, the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] pend, input logic last_grant);
        if (pend == 2'b11) begin
            return ~last_grant;
        end
        return pend[1] ? M1_IDX : M0_IDX;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response signals of both masters plus the memory-side bus.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [DW-1:0] i_m0_data;
    logic [AW-1:0] i_m0_address;
    logic [2:0]    i_m0_bhw;
    logic          i_m0_write_notread;
    logic          i_m0_DV;
    logic [DW-1:0] o_m0_data;
    logic          o_m0_DV;
    logic          o_m0_err;

    logic [DW-1:0] i_m1_data;
    logic [AW-1:0] i_m1_address;
    logic [2:0]    i_m1_bhw;
    logic          i_m1_write_notread;
    logic          i_m1_DV;
    logic [DW-1:0] o_m1_data;
    logic          o_m1_DV;
    logic          o_m1_err;

    logic [DW-1:0] o_bus_data;
    logic [AW-1:0] o_bus_address;
    logic [2:0]    o_bus_bhw;
    logic          o_bus_write_notread;
    logic          o_bus_DV;
    logic [DW-1:0] i_bus_data;
    logic          i_bus_DV;

    logic          o_protocol_err;

    // Arbiter side.
    modport slave (
        input  i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread, i_m0_DV,
        output o_m0_data, o_m0_DV, o_m0_err,
        input  i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread, i_m1_DV,
        output o_m1_data, o_m1_DV, o_m1_err,
        output o_bus_data, o_bus_address, o_bus_bhw, o_bus_write_notread, o_bus_DV,
        input  i_bus_data, i_bus_DV,
        output o_protocol_err
    );

    // Environment side: masters and memory.
    modport master (
        output i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread, i_m0_DV,
        input  o_m0_data, o_m0_DV, o_m0_err,
        output i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread, i_m1_DV,
        input  o_m1_data, o_m1_DV, o_m1_err,
        input  o_bus_data, o_bus_address, o_bus_bhw, o_bus_write_notread, o_bus_DV,
        output i_bus_data, i_bus_DV,
        input  o_protocol_err
    );
endinterface

// File: rtl/mem_bus_arbiter_req_latch.sv
// Holds one outstanding request for a single master and flags overruns.
module mem_bus_arbiter_req_latch #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_dv,
    input  logic [DW-1:0] i_data,
    input  logic [AW-1:0] i_address,
    input  logic [2:0]    i_bhw,
    input  logic          i_write_notread,
    input  logic          i_clr,
    output logic          o_pend,
    output logic [DW-1:0] o_data,
    output logic [AW-1:0] o_address,
    output logic [2:0]    o_bhw,
    output logic          o_write_notread,
    output logic          o_overrun
);
    logic          pend_q, pend_d;
    logic          accept;
    logic [DW-1:0] data_q;
    logic [AW-1:0] address_q;
    logic [2:0]    bhw_q;
    logic          write_notread_q;

    // A strobe in the cycle the pending request completes is a fresh request.
    assign accept    = i_dv && (!pend_q || i_clr);
    assign o_overrun = i_dv && pend_q && !i_clr;

    // Next pending state: completion clears, an accepted strobe sets.
    always_comb begin
        pend_d = pend_q;
        if (i_clr) begin
            pend_d = 1'b0;
        end
        if (accept) begin
            pend_d = 1'b1;
        end
    end

    // Pending flag register.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
        if (i_reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Request payload capture.
    always_ff @(posedge i_clk) begin
        // NOTE: payload carries no reset; it is only consumed while pend_q qualifies it.
        if (accept) begin
            data_q          <= i_data;
            address_q       <= i_address;
            bhw_q           <= i_bhw;
            write_notread_q <= i_write_notread;
        end
    end

    assign o_pend          = pend_q;
    assign o_data          = data_q;
    assign o_address       = address_q;
    assign o_bhw           = bhw_q;
    assign o_write_notread = write_notread_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for memory_top with a slave watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AW             = 32,
    parameter int DW             = 32
) (
    input logic               i_clk,
    input logic               i_reset,
    mem_bus_arbiter_if.slave  bus
);
    localparam int            CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            WD_ENABLE = (TIMEOUT_CYCLES != 0);
    // Forcing completion on this count puts the error strobe TIMEOUT_CYCLES after issue.
    localparam logic [CW-1:0] WD_FIRE   = CW'((TIMEOUT_CYCLES > 1) ? (TIMEOUT_CYCLES - 2) : 0);

    logic [1:0]          pend, overrun, clr, req_wnr;
    logic [1:0][DW-1:0]  req_data;
    logic [1:0][AW-1:0]  req_address;
    logic [1:0][2:0]     req_bhw;
    logic                pick, timeout_hit;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [CW-1:0]       wd_cnt_q, wd_cnt_d;
    logic [DW-1:0]       bus_data_q, bus_data_d;
    logic [AW-1:0]       bus_address_q, bus_address_d;
    logic [2:0]          bus_bhw_q, bus_bhw_d;
    logic                bus_wnr_q, bus_wnr_d;
    logic                bus_dv_q, bus_dv_d;
    logic [1:0][DW-1:0]  rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_dv_q, rsp_dv_d;
    logic [1:0]          rsp_err_q, rsp_err_d;
    logic                proto_err_q, proto_err_d;

    mem_bus_arbiter_req_latch #(.AW(AW), .DW(DW)) u_latch_m0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_dv(bus.i_m0_DV), .i_data(bus.i_m0_data),
        .i_address(bus.i_m0_address), .i_bhw(bus.i_m0_bhw),
        .i_write_notread(bus.i_m0_write_notread), .i_clr(clr[0]), .o_pend(pend[0]),
        .o_data(req_data[0]), .o_address(req_address[0]), .o_bhw(req_bhw[0]),
        .o_write_notread(req_wnr[0]), .o_overrun(overrun[0])
    );

    mem_bus_arbiter_req_latch #(.AW(AW), .DW(DW)) u_latch_m1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_dv(bus.i_m1_DV), .i_data(bus.i_m1_data),
        .i_address(bus.i_m1_address), .i_bhw(bus.i_m1_bhw),
        .i_write_notread(bus.i_m1_write_notread), .i_clr(clr[1]), .o_pend(pend[1]),
        .o_data(req_data[1]), .o_address(req_address[1]), .o_bhw(req_bhw[1]),
        .o_write_notread(req_wnr[1]), .o_overrun(overrun[1])
    );

    assign pick        = rr_pick(pend, last_grant_q);
    assign timeout_hit = WD_ENABLE && (wd_cnt_q == WD_FIRE);

    // Next-state, bus issue, watchdog and response routing.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        wd_cnt_d      = wd_cnt_q;
        bus_data_d    = bus_data_q;
        bus_address_d = bus_address_q;
        bus_bhw_d     = bus_bhw_q;
        bus_wnr_d     = bus_wnr_q;
        bus_dv_d      = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_dv_d      = '0;
        rsp_err_d     = '0;
        clr           = '0;
        proto_err_d   = proto_err_q | (|overrun);

        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    grant_d       = pick;
                    bus_data_d    = req_data[pick];
                    bus_address_d = req_address[pick];
                    bus_bhw_d     = req_bhw[pick];
                    bus_wnr_d     = req_wnr[pick];
                    bus_dv_d      = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wd_cnt_q != {CW{1'b1}}) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                // A real answer wins over a watchdog expiry in the same cycle.
                if (bus.i_bus_DV || timeout_hit) begin
                    clr[grant_q]        = 1'b1;
                    rsp_dv_d[grant_q]   = 1'b1;
                    rsp_err_d[grant_q]  = !bus.i_bus_DV;
                    rsp_data_d[grant_q] = (bus.i_bus_DV && !bus_wnr_q) ? bus.i_bus_data : '0;
                    last_grant_d        = grant_q;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= M1_IDX;
            grant_q       <= M0_IDX;
            wd_cnt_q      <= '0;
            bus_data_q    <= '0;
            bus_address_q <= '0;
            bus_bhw_q     <= '0;
            bus_wnr_q     <= 1'b0;
            bus_dv_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_dv_q      <= '0;
            rsp_err_q     <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            wd_cnt_q      <= wd_cnt_d;
            bus_data_q    <= bus_data_d;
            bus_address_q <= bus_address_d;
            bus_bhw_q     <= bus_bhw_d;
            bus_wnr_q     <= bus_wnr_d;
            bus_dv_q      <= bus_dv_d;
            rsp_data_q    <= rsp_data_d;
            rsp_dv_q      <= rsp_dv_d;
            rsp_err_q     <= rsp_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign bus.o_bus_data          = bus_data_q;
    assign bus.o_bus_address       = bus_address_q;
    assign bus.o_bus_bhw           = bus_bhw_q;
    assign bus.o_bus_write_notread = bus_wnr_q;
    assign bus.o_bus_DV            = bus_dv_q;
    assign bus.o_m0_data           = rsp_data_q[0];
    assign bus.o_m0_DV             = rsp_dv_q[0];
    assign bus.o_m0_err            = rsp_err_q[0];
    assign bus.o_m1_data           = rsp_data_q[1];
    assign bus.o_m1_DV             = rsp_dv_q[1];
    assign bus.o_m1_err            = rsp_err_q[1];
    assign bus.o_protocol_err      = proto_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (watchdog shortened to 16 cycles).
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n;
    int   k;
    int   cnt;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bif ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .AW(32), .DW(32)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bif)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_m0(input logic wnr, input logic [31:0] addr, input logic [31:0] wdata);
        bif.i_m0_DV = 1'b1;
        bif.i_m0_write_notread = wnr;
        bif.i_m0_address = addr;
        bif.i_m0_data = wdata;
        bif.i_m0_bhw = BHW_WORD;
    endtask

    task automatic req_m1(input logic wnr, input logic [31:0] addr, input logic [31:0] wdata);
        bif.i_m1_DV = 1'b1;
        bif.i_m1_write_notread = wnr;
        bif.i_m1_address = addr;
        bif.i_m1_data = wdata;
        bif.i_m1_bhw = BHW_WORD;
    endtask

    task automatic drop_strobes();
        bif.i_m0_DV = 1'b0;
        bif.i_m1_DV = 1'b0;
        bif.i_bus_DV = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drop_strobes();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits (bounded) for the issue strobe; returns the number of cycles waited.
    task automatic wait_issue(input string tag, output int cycles);
        cycles = 0;
        while (bif.o_bus_DV !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_issued"}, bif.o_bus_DV, 1'b1);
    endtask

    // Called in the issue cycle: memory answers 'delay' cycles later; returns in answer+1.
    task automatic serve(input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) tick();
        bif.i_bus_DV = 1'b1;
        bif.i_bus_data = rdata;
        tick();
        bif.i_bus_DV = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bif.i_m0_data = '0; bif.i_m0_address = '0; bif.i_m0_bhw = '0;
        bif.i_m0_write_notread = 1'b0; bif.i_m0_DV = 1'b0;
        bif.i_m1_data = '0; bif.i_m1_address = '0; bif.i_m1_bhw = '0;
        bif.i_m1_write_notread = 1'b0; bif.i_m1_DV = 1'b0;
        bif.i_bus_data = '0; bif.i_bus_DV = 1'b0;

        // Reset values, sampled while reset is held.
        tick();
        tick();
        check("rst_bus_dv", bif.o_bus_DV, 1'b0);
        check("rst_bus_addr", bif.o_bus_address, 32'h0);
        check("rst_m0_dv", bif.o_m0_DV, 1'b0);
        check("rst_m1_dv", bif.o_m1_DV, 1'b0);
        check("rst_m0_data", bif.o_m0_data, 32'h0);
        check("rst_proto_err", bif.o_protocol_err, 1'b0);
        rst = 1'b0;
        tick();

        // 1: M0 read, strobe at t, issue at t+2, answer 3 cycles after issue.
        req_m0(1'b0, 32'h0000_0100, 32'h0);
        tick();
        drop_strobes();
        check("t1_no_issue_t1", bif.o_bus_DV, 1'b0);
        tick();
        check("t1_issue_t2", bif.o_bus_DV, 1'b1);
        check("t1_addr", bif.o_bus_address, 32'h0000_0100);
        check("t1_wnr", bif.o_bus_write_notread, 1'b0);
        check("t1_bhw", bif.o_bus_bhw, BHW_WORD);
        tick();
        check("t1_dv_one_cycle", bif.o_bus_DV, 1'b0);
        check("t1_addr_held", bif.o_bus_address, 32'h0000_0100);
        tick();
        tick();
        bif.i_bus_DV = 1'b1;
        bif.i_bus_data = 32'hCAFE_BABE;
        check("t1_no_early_rsp", bif.o_m0_DV, 1'b0);
        tick();
        bif.i_bus_DV = 1'b0;
        check("t1_m0_dv", bif.o_m0_DV, 1'b1);
        check("t1_m0_data", bif.o_m0_data, 32'hCAFE_BABE);
        check("t1_m0_err", bif.o_m0_err, 1'b0);
        check("t1_m1_quiet", bif.o_m1_DV, 1'b0);
        tick();
        check("t1_m0_dv_pulse", bif.o_m0_DV, 1'b0);

        // 2: simultaneous strobes right after reset -> M0 then M1.
        apply_reset();
        req_m0(1'b0, 32'h0000_0300, 32'h0);
        req_m1(1'b0, 32'h0000_0400, 32'h0);
        tick();
        drop_strobes();
        wait_issue("t2a_first", n);
        check("t2a_first_lat", n, 1);
        check("t2a_first_is_m0", bif.o_bus_address, 32'h0000_0300);
        serve(1, 32'h1111_0000);
        check("t2a_m0_dv", bif.o_m0_DV, 1'b1);
        check("t2a_m0_data", bif.o_m0_data, 32'h1111_0000);
        check("t2a_m1_not_yet", bif.o_m1_DV, 1'b0);
        wait_issue("t2a_second", n);
        check("t2a_second_lat", n, 1);
        check("t2a_second_is_m1", bif.o_bus_address, 32'h0000_0400);
        serve(1, 32'h2222_0000);
        check("t2a_m1_dv", bif.o_m1_DV, 1'b1);
        check("t2a_m1_data", bif.o_m1_data, 32'h2222_0000);

        // 3: M1 word write; completion returns data 0 even if memory drives its data bus.
        req_m1(1'b1, 32'h0000_2000, 32'h1234_5678);
        tick();
        drop_strobes();
        wait_issue("t3", n);
        check("t3_addr", bif.o_bus_address, 32'h0000_2000);
        check("t3_wdata", bif.o_bus_data, 32'h1234_5678);
        check("t3_wnr", bif.o_bus_write_notread, 1'b1);
        check("t3_bhw", bif.o_bus_bhw, BHW_WORD);
        serve(2, 32'hDEAD_BEEF);
        check("t3_m1_dv", bif.o_m1_DV, 1'b1);
        check("t3_m1_data_zero", bif.o_m1_data, 32'h0);
        check("t3_m1_err", bif.o_m1_err, 1'b0);

        // 5: M0 strobes again while pending -> second dropped, sticky protocol error.
        req_m0(1'b0, 32'h0000_0500, 32'h0);
        tick();
        req_m0(1'b0, 32'h0000_0600, 32'h0);
        tick();
        drop_strobes();
        check("t5_issue", bif.o_bus_DV, 1'b1);
        check("t5_addr_first", bif.o_bus_address, 32'h0000_0500);
        check("t5_proto_set", bif.o_protocol_err, 1'b1);
        serve(1, 32'h5555_5555);
        check("t5_m0_data", bif.o_m0_data, 32'h5555_5555);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bif.o_bus_DV === 1'b1) cnt++;
            tick();
        end
        check("t5_dropped_not_issued", cnt, 0);
        check("t5_proto_sticky", bif.o_protocol_err, 1'b1);

        // 2b: M0 was served last, so the next simultaneous pair goes M1 then M0.
        req_m0(1'b0, 32'h0000_0700, 32'h0);
        req_m1(1'b0, 32'h0000_0800, 32'h0);
        tick();
        drop_strobes();
        wait_issue("t2b_first", n);
        check("t2b_first_is_m1", bif.o_bus_address, 32'h0000_0800);
        serve(1, 32'h8888_0000);
        check("t2b_m1_dv", bif.o_m1_DV, 1'b1);
        check("t2b_m1_data", bif.o_m1_data, 32'h8888_0000);
        wait_issue("t2b_second", n);
        check("t2b_second_is_m0", bif.o_bus_address, 32'h0000_0700);
        serve(1, 32'h7777_0000);
        check("t2b_m0_data", bif.o_m0_data, 32'h7777_0000);
        check("t2b_proto_sticky", bif.o_protocol_err, 1'b1);

        // 4: memory never answers -> error completion exactly 16 cycles after issue.
        req_m0(1'b0, 32'h0000_0B00, 32'h0);
        tick();
        drop_strobes();
        wait_issue("t4", n);
        k = 0;
        while (bif.o_m0_DV !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("t4_timeout_lat", k, 16);
        check("t4_err", bif.o_m0_err, 1'b1);
        check("t4_data_zero", bif.o_m0_data, 32'h0);
        tick();
        bif.i_bus_DV = 1'b1;
        bif.i_bus_data = 32'h0BAD_0BAD;
        tick();
        bif.i_bus_DV = 1'b0;
        check("t4_late_ignored_m0", bif.o_m0_DV, 1'b0);
        check("t4_late_ignored_m1", bif.o_m1_DV, 1'b0);
        req_m0(1'b0, 32'h0000_0C00, 32'h0);
        tick();
        drop_strobes();
        wait_issue("t4_next", n);
        check("t4_next_addr", bif.o_bus_address, 32'h0000_0C00);
        serve(1, 32'hC0C0_C0C0);
        check("t4_next_dv", bif.o_m0_DV, 1'b1);
        check("t4_next_data", bif.o_m0_data, 32'hC0C0_C0C0);
        check("t4_next_err", bif.o_m0_err, 1'b0);

        // 6: reset in WAIT aborts the transaction; the stale answer is ignored.
        req_m1(1'b0, 32'h0000_0D00, 32'h0);
        tick();
        drop_strobes();
        wait_issue("t6", n);
        tick();
        rst = 1'b1;
        tick();
        check("t6_bus_addr_zero", bif.o_bus_address, 32'h0);
        check("t6_bus_dv_zero", bif.o_bus_DV, 1'b0);
        check("t6_m1_data_zero", bif.o_m1_data, 32'h0);
        check("t6_proto_cleared", bif.o_protocol_err, 1'b0);
        rst = 1'b0;
        bif.i_bus_DV = 1'b1;
        bif.i_bus_data = 32'hEEEE_EEEE;
        tick();
        bif.i_bus_DV = 1'b0;
        check("t6_no_m1_rsp", bif.o_m1_DV, 1'b0);
        check("t6_no_m0_rsp", bif.o_m0_DV, 1'b0);
        tick();
        check("t6_no_reissue", bif.o_bus_DV, 1'b0);
        check("t6_no_m1_rsp_late", bif.o_m1_DV, 1'b0);

        // Strobe in the completion cycle of the same master is accepted, not an overrun.
        req_m1(1'b0, 32'h0000_0900, 32'h0);
        tick();
        drop_strobes();
        wait_issue("tc", n);
        tick();
        bif.i_bus_DV = 1'b1;
        bif.i_bus_data = 32'h9999_0000;
        req_m1(1'b0, 32'h0000_0A00, 32'h0);
        tick();
        drop_strobes();
        check("tc_m1_dv", bif.o_m1_DV, 1'b1);
        check("tc_m1_data", bif.o_m1_data, 32'h9999_0000);
        check("tc_no_proto", bif.o_protocol_err, 1'b0);
        wait_issue("tc_again", n);
        check("tc_again_lat", n, 1);
        check("tc_again_addr", bif.o_bus_address, 32'h0000_0A00);
        serve(1, 32'hAAAA_0000);
        check("tc_again_data", bif.o_m1_data, 32'hAAAA_0000);
        check("tc_no_proto_end", bif.o_protocol_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
